// File: rtl/ps2_status_arbiter.sv
// ps2_status_arbiter
// Shares BRAM Port A between CPU_Control and the PS2 key-status mirror.
// Status changes are coalesced and written to STATUS_ADDR as {seq, snap},
// stealing single memory cycles from the CPU through cpu_stall. A starvation
// counter forces the steal once a pending update has yielded STARVE_LIMIT cycles.
// Optional feature macro: STATUS_WRITE_PROTECT_EN (CPU writes to STATUS_ADDR
// are suppressed so the status word is read-only to software).
module ps2_status_arbiter #(
  parameter logic [15:0] STATUS_ADDR  = 16'h03F0,
  parameter int          STARVE_LIMIT = 8,
  parameter int          SEQ_W        = 10
) (
  input  logic        CLOCK_50,
  input  logic        KEY0,
  input  logic [5:0]  key_status,
  input  logic        cpu_mem_req,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_we,
  input  logic [15:0] cpu_din,
  output logic [15:0] mem_addr,
  output logic        mem_we,
  output logic [15:0] mem_din,
  output logic        cpu_stall,
  output logic        upd_pending
);

  localparam int STARVE_W = (STARVE_LIMIT > 2) ? $clog2(STARVE_LIMIT) : 1;
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT - 1);

  typedef enum logic [2:0] {
    ST_INIT    = 3'd0,
    ST_IDLE    = 3'd1,
    ST_PEND    = 3'd2,
    ST_WRITE   = 3'd3,
    ST_RECOVER = 3'd4
  } state_t;

  state_t              r_state;
  logic [5:0]          r_last_written;
  logic [5:0]          r_snap;
  logic [SEQ_W-1:0]    r_seq;
  logic [STARVE_W-1:0] r_starve;
  // Output flags are registered together with the state so they never glitch.
  logic                r_steal;
  logic                r_stall;
  logic                r_pending;

  logic                w_key_changed;
  logic                w_pass_we;
  logic [15:0]         w_mem_addr;
  logic                w_mem_we;
  logic [15:0]         w_mem_din;

  assign w_key_changed = (key_status != r_last_written);

  // Arbitration FSM: tracks pending updates, starvation and the two stall cycles.
  always_ff @(posedge CLOCK_50 or negedge KEY0) begin
    if (!KEY0) begin
      r_state        <= ST_INIT;
      r_last_written <= 6'd0;
      r_snap         <= 6'd0;
      r_seq          <= '0;
      r_starve       <= '0;
      r_steal        <= 1'b0;
      r_stall        <= 1'b0;
      r_pending      <= 1'b0;
    end else begin
      case (r_state)
        ST_INIT: begin
          // Unconditionally initialise the status word after reset.
          r_snap    <= key_status;
          r_state   <= ST_WRITE;
          r_steal   <= 1'b1;
          r_stall   <= 1'b1;
          r_pending <= 1'b1;
        end
        ST_IDLE: begin
          if (w_key_changed) begin
            r_snap    <= key_status;
            r_state   <= ST_PEND;
            r_pending <= 1'b1;
          end else begin
            r_state   <= ST_IDLE;
          end
        end
        ST_PEND: begin
          // Coalesce: always carry the newest value into the write.
          if (key_status != r_snap) begin
            r_snap <= key_status;
          end else begin
            r_snap <= r_snap;
          end
          if (!cpu_mem_req || (r_starve == STARVE_MAX)) begin
            r_state   <= ST_WRITE;
            r_steal   <= 1'b1;
            r_stall   <= 1'b1;
            r_pending <= 1'b1;
          end else begin
            r_starve  <= r_starve + STARVE_W'(1);
          end
        end
        ST_WRITE: begin
          r_last_written <= r_snap;
          r_seq          <= r_seq + SEQ_W'(1);
          r_starve       <= '0;
          r_state        <= ST_RECOVER;
          r_steal        <= 1'b0;
          r_stall        <= 1'b1;
          r_pending      <= 1'b0;
        end
        ST_RECOVER: begin
          // A change that arrived during WRITE is picked up here.
          r_stall <= 1'b0;
          if (w_key_changed) begin
            r_snap    <= key_status;
            r_state   <= ST_PEND;
            r_pending <= 1'b1;
          end else begin
            r_state   <= ST_IDLE;
            r_pending <= 1'b0;
          end
        end
        default: begin
          r_state   <= ST_INIT;
          r_steal   <= 1'b0;
          r_stall   <= 1'b0;
          r_pending <= 1'b0;
        end
      endcase
    end
  end

  // Port A mux: status write during a steal, CPU passthrough otherwise.
  always_comb begin
    w_pass_we  = cpu_we;
`ifdef STATUS_WRITE_PROTECT_EN
    if (cpu_addr == STATUS_ADDR) begin
      w_pass_we = 1'b0;
    end else begin
      w_pass_we = cpu_we;
    end
`endif
    w_mem_addr = cpu_addr;
    w_mem_we   = w_pass_we;
    w_mem_din  = cpu_din;
    if (r_steal) begin
      w_mem_addr = STATUS_ADDR;
      w_mem_we   = 1'b1;
      w_mem_din  = {r_seq, r_snap};
    end else begin
      w_mem_addr = cpu_addr;
      w_mem_we   = w_pass_we;
      w_mem_din  = cpu_din;
    end
  end

  assign mem_addr    = w_mem_addr;
  assign mem_we      = w_mem_we;
  assign mem_din     = w_mem_din;
  assign cpu_stall   = r_stall;
  assign upd_pending = r_pending;

endmodule

// File: tb/tb_ps2_status_arbiter.sv
// Directed, table-driven bench for ps2_status_arbiter with a small BRAM model.
module tb_ps2_status_arbiter;

  localparam logic [15:0] SADDR = 16'h03F0;
`ifdef STATUS_WRITE_PROTECT_EN
  localparam bit WP = 1'b1;
`else
  localparam bit WP = 1'b0;
`endif

  logic        CLOCK_50;
  logic        KEY0;
  logic [5:0]  key_status;
  logic        cpu_mem_req;
  logic [15:0] cpu_addr;
  logic        cpu_we;
  logic [15:0] cpu_din;
  logic [15:0] mem_addr;
  logic        mem_we;
  logic [15:0] mem_din;
  logic        cpu_stall;
  logic        upd_pending;

  ps2_status_arbiter dut (
    .CLOCK_50    (CLOCK_50),
    .KEY0        (KEY0),
    .key_status  (key_status),
    .cpu_mem_req (cpu_mem_req),
    .cpu_addr    (cpu_addr),
    .cpu_we      (cpu_we),
    .cpu_din     (cpu_din),
    .mem_addr    (mem_addr),
    .mem_we      (mem_we),
    .mem_din     (mem_din),
    .cpu_stall   (cpu_stall),
    .upd_pending (upd_pending)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  // BRAM Port A model.
  logic [15:0] bram [0:65535];
  always @(posedge CLOCK_50) begin
    if (mem_we) bram[mem_addr] <= mem_din;
  end

  typedef struct {
    logic        req;
    logic [15:0] addr;
    logic        we;
    logic [15:0] din;
    logic [5:0]  key;
    logic [15:0] e_addr;
    logic        e_we;
    logic [15:0] e_din;
    logic        e_stall;
    logic        e_pend;
    logic        chk_mem;
    logic [15:0] e_mem;
  } vec_t;

  vec_t vec [0:63];
  int   n_vec;
  int   n_tests;
  int   n_fail;

  task automatic chk(input string nm, input logic [39:0] act, input logic [39:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // CPU passthrough cycle; expected write enable follows the protect option.
  task automatic pass(input logic req, input logic [15:0] addr, input logic we,
                      input logic [15:0] din, input logic [5:0] key,
                      input logic stall, input logic pend);
    vec[n_vec] = '{req, addr, we, din, key, addr,
                   we & ~(WP & (addr == SADDR)), din, stall, pend, 1'b0, 16'h0000};
    n_vec++;
  endtask

  // Stolen cycle: status word driven regardless of the CPU inputs.
  task automatic steal(input logic req, input logic [5:0] key, input logic [15:0] e_din);
    vec[n_vec] = '{req, 16'h0300, 1'b1, 16'h7777, key, SADDR, 1'b1, e_din,
                   1'b1, 1'b1, 1'b0, 16'h0000};
    n_vec++;
  endtask

  task automatic mem_expect(input logic [15:0] v);
    vec[n_vec-1].chk_mem = 1'b1;
    vec[n_vec-1].e_mem   = v;
  endtask

  function automatic logic [39:0] outs();
    return {5'd0, mem_addr, mem_we, mem_din, cpu_stall, upd_pending};
  endfunction

  function automatic logic [39:0] pack(input logic [15:0] a, input logic w,
                                       input logic [15:0] d, input logic s, input logic p);
    return {5'd0, a, w, d, s, p};
  endfunction

  initial begin
    n_vec = 0; n_tests = 0; n_fail = 0;

    // Reset init write, then idle-CPU update (seq 1).
    steal(1'b0, 6'b000001, 16'h0001);
    pass(1'b1, 16'h0200, 1'b0, 16'h1234, 6'b000001, 1'b1, 1'b0);
    pass(1'b0, 16'h0200, 1'b0, 16'h1234, 6'b100000, 1'b0, 1'b0);
    pass(1'b0, 16'h0200, 1'b0, 16'h1234, 6'b100000, 1'b0, 1'b1);
    steal(1'b0, 6'b100000, 16'h0060);
    pass(1'b1, 16'h03F0, 1'b0, 16'h1234, 6'b100000, 1'b1, 1'b0);
    mem_expect(16'h0060);
    // CPU write to the status word.
    pass(1'b1, 16'h03F0, 1'b0, 16'h0000, 6'b100000, 1'b0, 1'b0);
    pass(1'b1, 16'h03F0, 1'b1, 16'hFFFF, 6'b100000, 1'b0, 1'b0);
    pass(1'b1, 16'h0300, 1'b0, 16'h0000, 6'b100000, 1'b0, 1'b0);
    mem_expect(WP ? 16'h0060 : 16'hFFFF);
    // Starvation: CPU busy, forced steal 9 cycles after the change.
    pass(1'b1, 16'h0300, 1'b0, 16'h0000, 6'b000010, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) pass(1'b1, 16'h0300, 1'b0, 16'h0000, 6'b000010, 1'b0, 1'b1);
    steal(1'b1, 6'b000010, 16'h0082);
    pass(1'b1, 16'h0300, 1'b0, 16'h0000, 6'b000010, 1'b1, 1'b0);
    pass(1'b1, 16'h0300, 1'b0, 16'h0000, 6'b000010, 1'b0, 1'b0);
    mem_expect(16'h0082);
    // Coalescing of three changes while pending.
    pass(1'b1, 16'h0300, 1'b0, 16'h0000, 6'b000100, 1'b0, 1'b0);
    pass(1'b1, 16'h0300, 1'b0, 16'h0000, 6'b001000, 1'b0, 1'b1);
    pass(1'b1, 16'h0300, 1'b0, 16'h0000, 6'b010000, 1'b0, 1'b1);
    pass(1'b1, 16'h0300, 1'b0, 16'h0000, 6'b110000, 1'b0, 1'b1);
    pass(1'b0, 16'h0300, 1'b0, 16'h0000, 6'b110000, 1'b0, 1'b1);
    steal(1'b0, 6'b110000, 16'h00F0);
    pass(1'b0, 16'h0300, 1'b0, 16'h0000, 6'b110000, 1'b1, 1'b0);
    pass(1'b0, 16'h0300, 1'b0, 16'h0000, 6'b000000, 1'b0, 1'b0);
    mem_expect(16'h00F0);
    // Next write must carry seq 4; key changes during WRITE.
    pass(1'b0, 16'h0300, 1'b0, 16'h0000, 6'b000000, 1'b0, 1'b1);
    steal(1'b0, 6'b000011, 16'h0100);
    pass(1'b0, 16'h0300, 1'b0, 16'h0000, 6'b000011, 1'b1, 1'b0);
    pass(1'b0, 16'h0300, 1'b0, 16'h0000, 6'b000011, 1'b0, 1'b1);
    steal(1'b0, 6'b000011, 16'h0143);
    pass(1'b0, 16'h0300, 1'b0, 16'h0000, 6'b000011, 1'b1, 1'b0);
    // Key returns to last_written while pending: still written.
    pass(1'b0, 16'h0300, 1'b0, 16'h0000, 6'b000111, 1'b0, 1'b0);
    pass(1'b1, 16'h0300, 1'b0, 16'h0000, 6'b000011, 1'b0, 1'b1);
    pass(1'b0, 16'h0300, 1'b0, 16'h0000, 6'b000011, 1'b0, 1'b1);
    steal(1'b0, 6'b000011, 16'h0183);
    pass(1'b0, 16'h0300, 1'b0, 16'h0000, 6'b000011, 1'b1, 1'b0);
    pass(1'b0, 16'h0300, 1'b0, 16'h0000, 6'b000011, 1'b0, 1'b0);
    mem_expect(16'h0183);

    // Reset state.
    KEY0 = 1'b1; key_status = 6'b000001;
    cpu_mem_req = 1'b0; cpu_addr = 16'h0100; cpu_we = 1'b1; cpu_din = 16'hABCD;
    #1 KEY0 = 1'b0;
    #1 chk("reset_outputs", outs(), pack(16'h0100, 1'b1, 16'hABCD, 1'b0, 1'b0));
    @(posedge CLOCK_50); #1;
    chk("reset_hold", outs(), pack(16'h0100, 1'b1, 16'hABCD, 1'b0, 1'b0));
    cpu_we = 1'b0; cpu_din = 16'h0000;
    @(negedge CLOCK_50); KEY0 = 1'b1;
    @(posedge CLOCK_50); #1;

    for (int i = 0; i < n_vec; i++) begin
      cpu_mem_req = vec[i].req;  cpu_addr = vec[i].addr;
      cpu_we      = vec[i].we;   cpu_din  = vec[i].din;
      key_status  = vec[i].key;
      #1;
      chk($sformatf("vec%0d", i), outs(),
          pack(vec[i].e_addr, vec[i].e_we, vec[i].e_din, vec[i].e_stall, vec[i].e_pend));
      if (vec[i].chk_mem) chk($sformatf("mem%0d", i), {24'd0, bram[SADDR]}, {24'd0, vec[i].e_mem});
      @(posedge CLOCK_50); #1;
    end

    // Reset asserted in the middle of WRITE, then INIT rewrites with seq 0.
    key_status = 6'b101010; cpu_mem_req = 1'b0;
    cpu_addr = 16'h0400; cpu_we = 1'b1; cpu_din = 16'h5555;
    @(posedge CLOCK_50); #1;
    chk("abort_pend", outs(), pack(16'h0400, 1'b1, 16'h5555, 1'b0, 1'b1));
    @(posedge CLOCK_50); #1;
    chk("abort_write", outs(), pack(SADDR, 1'b1, 16'h01EA, 1'b1, 1'b1));
    KEY0 = 1'b0;
    #1 chk("abort_reset", outs(), pack(16'h0400, 1'b1, 16'h5555, 1'b0, 1'b0));
    key_status = 6'b010101;
    @(negedge CLOCK_50); KEY0 = 1'b1;
    @(posedge CLOCK_50); #1;
    chk("reinit_write", outs(), pack(SADDR, 1'b1, 16'h0015, 1'b1, 1'b1));
    @(posedge CLOCK_50); #1;
    chk("reinit_recover", outs(), pack(16'h0400, 1'b1, 16'h5555, 1'b1, 1'b0));
    chk("reinit_mem", {24'd0, bram[SADDR]}, {24'd0, 16'h0015});
    @(posedge CLOCK_50); #1;
    chk("reinit_idle", outs(), pack(16'h0400, 1'b1, 16'h5555, 1'b0, 1'b0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_status_arbiter.md
# ps2_status_arbiter

Shares BRAM Port A between CPU_Control and the PS2 key-status source so the 6-bit key_status (W, A, S, D, Space, R) is mirrored into memory at STATUS_ADDR without CPU involvement. The block sits between CPU_Control's memory request signals and the BRAM Port A pins. It detects status changes, coalesces them, and steals single memory cycles from the CPU via a stall. A starvation counter bounds the latency of each update.

## Interface
- STATUS_ADDR, 16'h03F0, word address of the status register in BRAM.
- STARVE_LIMIT, 8, maximum number of cycles a pending update yields to active CPU requests before a forced steal.
- SEQ_W, 10, width of the update sequence counter packed into the upper bits of the status word.

- CLOCK_50  in  1  system clock; all state updates on the rising edge.
- KEY0  in  1  asynchronous active-low reset.
- key_status  in  6  live status from the PS2 block, synchronous to CLOCK_50.
- cpu_mem_req  in  1  CPU is issuing a memory access this cycle.
- cpu_addr  in  16  CPU address.
- cpu_we  in  1  CPU write enable.
- cpu_din  in  16  CPU write data.
- mem_addr  out  16  BRAM Port A address.
- mem_we  out  1  BRAM Port A write enable.
- mem_din  out  16  BRAM Port A write data.
- cpu_stall  out  1  when high, the CPU must hold its current request and discard mem_dout in the following cycle.
- upd_pending  out  1  a status update is waiting to be written.

## Operation
- Registers:
  - last_written[5:0]: status value most recently written to memory.
  - snap[5:0]: status value waiting to be written.
  - seq[SEQ_W-1:0]: update sequence counter.
  - starve counter: counts cycles a pending update has yielded.
- Written status word: {seq, snap}. seq increments by 1 on every status write and wraps modulo 2^SEQ_W.
- FSM states: INIT, IDLE, PEND, WRITE, RECOVER.
  - INIT: entered on reset. Goes to WRITE with snap = key_status, so the status word is initialised after reset.
  - IDLE: if key_status != last_written, latch snap and go to PEND.
  - PEND:
    - Each cycle, if key_status != snap, reload snap (coalescing).
    - If cpu_mem_req is 0, go to WRITE.
    - Otherwise increment the starve counter. When the counter reaches STARVE_LIMIT-1, go to WRITE regardless of cpu_mem_req.
  - WRITE:
    - Drives mem_addr = STATUS_ADDR, mem_we = 1, mem_din = {seq, snap}, cpu_stall = 1.
    - On exit: last_written <= snap, seq <= seq+1, starve counter cleared. Go to RECOVER.
  - RECOVER:
    - Passes the CPU request through to memory, with cpu_stall = 1, so the CPU's re-presented read data is aligned on the next cycle.
    - Then go to IDLE. If key_status != last_written at this point, go directly to PEND with snap latched.
- In IDLE, PEND and RECOVER, mem_addr/mem_we/mem_din follow cpu_addr/cpu_we/cpu_din combinationally.
- In IDLE and PEND, cpu_stall = 0.
- upd_pending is 1 in PEND and WRITE, 0 otherwise.
- If key_status changes during WRITE, the write uses snap (the old value). The change is picked up in RECOVER.
- If key_status returns to last_written while in PEND, the update is still written (with a new seq). It is not cancelled.

## Timing
- Reset (KEY0 = 0), asynchronously:
  - state = INIT, seq = 0, last_written = 0, snap = 0, starve counter = 0.
  - Outputs: cpu_stall = 0, upd_pending = 0, mem_we = cpu_we passthrough.
- The first rising edge after KEY0 releases enters WRITE, storing {0, key_status}.
- A key_status change seen in IDLE at edge t:
  - With CPU idle, the memory write occurs in cycle t+2 (PEND at t+1, WRITE at t+2).
  - With the CPU continuously busy, the write occurs no later than cycle t+1+STARVE_LIMIT.
- Each update stalls the CPU for exactly 2 cycles (WRITE, RECOVER).
- A KEY0 assertion in the middle of WRITE aborts the write. The BRAM may or may not have been written; INIT rewrites it.

## Configuration
- STATUS_WRITE_PROTECT_EN:
  - When defined, CPU writes with cpu_addr == STATUS_ADDR are suppressed (mem_we forced to 0 for that access), so the status word is read-only to software.
  - When undefined, CPU writes to STATUS_ADDR pass through unmodified and may be overwritten by the next status update.

## Test plan
- Reset release with key_status = 6'b000001: the cycle after reset shows mem_addr = 16'h03F0, mem_we = 1, mem_din = 16'h0001, and cpu_stall is high for 2 cycles.
- CPU idle, key_status 000000 -> 100000: mem_din = 16'h0060 (seq = 1) at STATUS_ADDR exactly 2 cycles after the change; a later CPU read of 0x03F0 returns 0x0060.
- cpu_mem_req held at 1, status change, STARVE_LIMIT = 8: the write happens 9 cycles after the change, and cpu_stall is asserted only in the WRITE and RECOVER cycles.
- Three status changes on consecutive cycles while in PEND with the CPU busy: a single write carrying the final value, and seq increments by exactly 1.
- With STATUS_WRITE_PROTECT_EN defined, CPU write of 0xFFFF to 0x03F0: mem_we = 0 and the readback is unchanged. Without the macro, the readback is 0xFFFF until the next status change.
- KEY0 asserted during WRITE: outputs immediately show the reset values; after release, INIT writes {0, key_status}.
